// File: rtl/fft_frame_sequencer.sv
// In-place radix-2 DIT FFT frame engine: bit-reversed load, LOGN butterfly stages
// through an external combinational butterfly, natural-order unload, Done/Ack handshake.
module fft_frame_sequencer #(
    parameter int PRE  = 32,
    parameter int LOGN = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Ack,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [PRE-1:0] in_re,
    input  logic signed [PRE-1:0] in_im,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [PRE-1:0] out_re,
    output logic signed [PRE-1:0] out_im,
    output logic [LOGN-1:0]       out_index,
    output logic [9:0]            bf_address,
    output logic signed [PRE-1:0] bf_x_top_re,
    output logic signed [PRE-1:0] bf_x_top_im,
    output logic signed [PRE-1:0] bf_x_bot_re,
    output logic signed [PRE-1:0] bf_x_bot_im,
    input  logic signed [PRE-1:0] bf_y_top_re,
    input  logic signed [PRE-1:0] bf_y_top_im,
    input  logic signed [PRE-1:0] bf_y_bot_re,
    input  logic signed [PRE-1:0] bf_y_bot_im,
    output logic                  Done,
    output logic [3:0]            state
);

    localparam int N = 1 << LOGN;

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] DONE   = 4'd1;
    localparam logic [3:0] PROC   = 4'd2;
    localparam logic [3:0] LOAD   = 4'd3;
    localparam logic [3:0] UNLOAD = 4'd4;

    localparam logic [LOGN-1:0] K_LAST = LOGN'(N - 1);
    localparam logic [LOGN-1:0] B_LAST = LOGN'(N / 2 - 1);
    localparam logic [3:0]      S_LAST = 4'(LOGN - 1);

    logic [3:0]      state_q;
    logic [LOGN-1:0] k;
    logic [LOGN-1:0] b;
    logic [3:0]      s;

    logic signed [PRE-1:0] mem_re [N];
    logic signed [PRE-1:0] mem_im [N];

    logic [LOGN-1:0] half;
    logic [LOGN-1:0] mask;
    logic [LOGN-1:0] i_top;
    logic [LOGN-1:0] i_bot;
    logic [9:0]      tw_idx;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = v[LOGN-1-i];
        end
        return r;
    endfunction

    // b enumerates butterflies; insert a zero at bit s to get the top index of the pair
    always_comb begin
        half   = LOGN'(1) << s;
        mask   = half - LOGN'(1);
        i_top  = ((b >> s) << (s + 4'd1)) | (b & mask);
        i_bot  = i_top + half;
        tw_idx = 10'(b & mask) << (4'd9 - s);
    end

    assign state      = state_q;
    assign in_ready   = (state_q == LOAD);
    assign out_valid  = (state_q == UNLOAD);
    assign Done       = (state_q == DONE);
    assign out_index  = out_valid ? k : '0;
    assign out_re     = mem_re[k];
    assign out_im     = mem_im[k];
    assign bf_address = (state_q == PROC) ? tw_idx : 10'd0;

    assign bf_x_top_re = mem_re[i_top];
    assign bf_x_top_im = mem_im[i_top];
    assign bf_x_bot_re = mem_re[i_bot];
    assign bf_x_bot_im = mem_im[i_bot];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            k       <= '0;
            b       <= '0;
            s       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        state_q <= LOAD;
                        k       <= '0;
                        b       <= '0;
                        s       <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        k <= k + LOGN'(1);
                        if (k == K_LAST) begin
                            state_q <= PROC;
                            b       <= '0;
                            s       <= '0;
                        end
                    end
                end
                PROC: begin
                    if (b == B_LAST) begin
                        b <= '0;
                        if (s == S_LAST) begin
                            state_q <= UNLOAD;
                            s       <= '0;
                            k       <= '0;
                        end else begin
                            s <= s + 4'd1;
                        end
                    end else begin
                        b <= b + LOGN'(1);
                    end
                end
                UNLOAD: begin
                    if (out_ready) begin
                        k <= k + LOGN'(1);
                        if (k == K_LAST) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (Ack) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sample memory carries no reset; contents are only meaningful within a frame
    always_ff @(posedge Clk) begin
        if (state_q == LOAD && in_valid) begin
            mem_re[bitrev(k)] <= in_re;
            mem_im[bitrev(k)] <= in_im;
        end else if (state_q == PROC) begin
            mem_re[i_top] <= bf_y_top_re;
            mem_im[i_top] <= bf_y_top_im;
            mem_re[i_bot] <= bf_y_bot_re;
            mem_im[i_bot] <= bf_y_bot_im;
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer (N=256) with a behavioural butterfly that
// is either a pass-through (index tracing) or a real-valued twiddle butterfly.
module tb_fft_frame_sequencer;

    logic               Clk = 1'b0;
    logic               Reset = 1'b0;
    logic               Start = 1'b0;
    logic               Ack = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] in_re = '0;
    logic signed [31:0] in_im = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [31:0] out_re;
    logic signed [31:0] out_im;
    logic [7:0]         out_index;
    logic [9:0]         bf_address;
    logic signed [31:0] bf_x_top_re, bf_x_top_im, bf_x_bot_re, bf_x_bot_im;
    logic signed [31:0] bf_y_top_re, bf_y_top_im, bf_y_bot_re, bf_y_bot_im;
    logic               Done;
    logic [3:0]         state;

    fft_frame_sequencer #(.PRE(32), .LOGN(8)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_index(out_index), .bf_address(bf_address),
        .bf_x_top_re(bf_x_top_re), .bf_x_top_im(bf_x_top_im),
        .bf_x_bot_re(bf_x_bot_re), .bf_x_bot_im(bf_x_bot_im),
        .bf_y_top_re(bf_y_top_re), .bf_y_top_im(bf_y_top_im),
        .bf_y_bot_re(bf_y_bot_re), .bf_y_bot_im(bf_y_bot_im),
        .Done(Done), .state(state)
    );

    always #5 Clk = ~Clk;

    logic bf_fft = 1'b0;
    real  ang, wr, wi, tr, ti;
    int   tri_re, tri_im;

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    always @* begin
        ang = 6.283185307179586 * real'(bf_address) / 1024.0;
        wr  = $cos(ang);
        wi  = -$sin(ang);
        tr  = real'(bf_x_bot_re) * wr - real'(bf_x_bot_im) * wi;
        ti  = real'(bf_x_bot_re) * wi + real'(bf_x_bot_im) * wr;
        tri_re = rnd(tr);
        tri_im = rnd(ti);
        if (bf_fft) begin
            bf_y_top_re = bf_x_top_re + tri_re;
            bf_y_top_im = bf_x_top_im + tri_im;
            bf_y_bot_re = bf_x_top_re - tri_re;
            bf_y_bot_im = bf_x_top_im - tri_im;
        end else begin
            bf_y_top_re = bf_x_top_re;
            bf_y_top_im = bf_x_top_im;
            bf_y_bot_re = bf_x_bot_re;
            bf_y_bot_im = bf_x_bot_im;
        end
    end

    int tests = 0;
    int fails = 0;
    int src_re [256];
    int src_im [256];
    int res_re [256];
    int res_im [256];

    function automatic int bitrev8(input int v);
        int r = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r[7-i] = 1'b1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_frame();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("start_state_load", state, 3);
        chk("start_in_ready", in_ready, 1);
    endtask

    task automatic load_frame(input bit rnd_valid);
        int k = 0;
        int guard = 0;
        bit v;
        while (k < 256 && guard < 5000) begin
            if (in_ready) begin
                v = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                in_valid = v;
                in_re = src_re[k];
                in_im = src_im[k];
                if (v) k++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge Clk);
            guard++;
        end
        in_valid = 1'b0;
        chk("load_transfers", k, 256);
    endtask

    task automatic run_proc(input bit trace, input int rst_at, input int start_at, output int cycles);
        int bad0 = 0;
        cycles = 0;
        while (state == 4'd2 && cycles < 3000) begin
            if (trace) begin
                if (cycles == 0) begin
                    chk("proc_first_top", bf_x_top_re, 0);
                    chk("proc_first_bot", bf_x_bot_re, 128);
                    chk("proc_first_addr", bf_address, 0);
                end
                if (cycles < 128 && bf_address != 10'd0) bad0++;
                if (cycles == 261) begin
                    chk("s2b5_top_is_mem9", bf_x_top_re, 144);
                    chk("s2b5_bot_is_mem13", bf_x_bot_re, 176);
                    chk("s2b5_addr", bf_address, 128);
                end
                if (cycles == 1023) begin
                    chk("s7b127_top_is_mem127", bf_x_top_re, 254);
                    chk("s7b127_bot_is_mem255", bf_x_bot_re, 255);
                    chk("s7b127_bot_im", bf_x_bot_im, -255);
                    chk("s7b127_addr", bf_address, 508);
                end
            end
            Start = (cycles == start_at);
            Reset = (cycles == rst_at);
            @(negedge Clk);
            cycles++;
        end
        Start = 1'b0;
        Reset = 1'b0;
        if (trace) chk("stage0_nonzero_addr", bad0, 0);
    endtask

    task automatic unload_frame(input bit rnd_ready, output int cycles);
        int idx = 0;
        int seq_bad = 0;
        int unstable = 0;
        bit held = 1'b0;
        bit r;
        logic signed [31:0] h_re, h_im;
        logic [7:0] h_idx;
        cycles = 0;
        while (state == 4'd4 && cycles < 5000) begin
            if (held && (out_re !== h_re || out_im !== h_im || out_index !== h_idx)) unstable++;
            r = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = r;
            if (r) begin
                if (int'(out_index) != idx) seq_bad++;
                if (idx < 256) begin
                    res_re[idx] = out_re;
                    res_im[idx] = out_im;
                end
                idx++;
            end
            held = !r;
            h_re = out_re;
            h_im = out_im;
            h_idx = out_index;
            @(negedge Clk);
            cycles++;
        end
        out_ready = 1'b0;
        chk("unload_transfers", idx, 256);
        chk("unload_index_seq_errors", seq_bad, 0);
        chk("stall_unstable", unstable, 0);
    endtask

    task automatic check_done();
        chk("done_flag", Done, 1);
        chk("done_state", state, 1);
        chk("done_out_valid", out_valid, 0);
    endtask

    task automatic ack_frame(input bit with_start);
        Ack = 1'b1;
        Start = with_start;
        @(negedge Clk);
        Ack = 1'b0;
        Start = 1'b0;
        chk("ack_state_idle", state, 0);
        chk("ack_done_low", Done, 0);
        if (with_start) begin
            @(negedge Clk);
            chk("ack_start_still_idle", state, 0);
            chk("ack_start_in_ready", in_ready, 0);
        end
    endtask

    task automatic set_impulse();
        for (int i = 0; i < 256; i++) begin
            src_re[i] = (i == 0) ? 1000 : 0;
            src_im[i] = 0;
        end
    endtask

    task automatic check_impulse(input string tag);
        int bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (res_re[i] != 1000 || res_im[i] != 0) bad++;
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        int pc, uc, bad;

        @(negedge Clk);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_done", Done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_bf_address", bf_address, 0);

        // Pass-through butterfly: load order and butterfly index trace
        bf_fft = 1'b0;
        for (int i = 0; i < 256; i++) begin
            src_re[i] = i;
            src_im[i] = -i;
        end
        start_frame();
        load_frame(1'b0);
        run_proc(1'b1, -1, -1, pc);
        chk("trace_proc_cycles", pc, 1024);
        unload_frame(1'b0, uc);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (res_re[i] != bitrev8(i) || res_im[i] != -bitrev8(i)) bad++;
        end
        chk("bitrev_store_errors", bad, 0);
        chk("out1_is_x128", res_re[1], 128);
        check_done();
        ack_frame(1'b0);

        // Impulse with Start pulsed mid-PROC
        bf_fft = 1'b1;
        set_impulse();
        start_frame();
        load_frame(1'b0);
        run_proc(1'b0, -1, 100, pc);
        chk("impulse_proc_cycles", pc, 1024);
        unload_frame(1'b0, uc);
        chk("impulse_unload_cycles", uc, 256);
        chk("impulse_start_to_done", pc + uc, 1280);
        check_impulse("impulse_bin_errors");
        check_done();
        ack_frame(1'b0);

        // DC frame under random backpressure, then Start+Ack together
        for (int i = 0; i < 256; i++) begin
            src_re[i] = 100;
            src_im[i] = 0;
        end
        start_frame();
        load_frame(1'b1);
        run_proc(1'b0, -1, -1, pc);
        chk("dc_proc_cycles", pc, 1024);
        unload_frame(1'b1, uc);
        chk("dc_bin0_re", res_re[0], 25600);
        chk("dc_bin0_im", res_im[0], 0);
        bad = 0;
        for (int i = 1; i < 256; i++) begin
            if (res_re[i] < -8 || res_re[i] > 8 || res_im[i] < -8 || res_im[i] > 8) bad++;
        end
        chk("dc_other_bins_out_of_tol", bad, 0);
        check_done();
        ack_frame(1'b1);

        // Reset at PROC cycle 300, then a clean impulse frame
        set_impulse();
        start_frame();
        load_frame(1'b0);
        run_proc(1'b0, 300, -1, pc);
        chk("midrst_proc_cycles", pc, 301);
        chk("midrst_state", state, 0);
        chk("midrst_done", Done, 0);
        chk("midrst_in_ready", in_ready, 0);
        start_frame();
        load_frame(1'b0);
        run_proc(1'b0, -1, -1, pc);
        chk("post_rst_proc_cycles", pc, 1024);
        unload_frame(1'b0, uc);
        check_impulse("post_rst_impulse_errors");
        check_done();
        ack_frame(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Sequences one complete in-place radix-2 decimation-in-time FFT frame around the combinational `fft_butterfly_unit`. It owns the complex sample memory, accepts N samples over a valid/ready stream and stores them in bit-reversed order, then drives the butterfly with index pairs and twiddle addresses for all log2(N) stages, writing the results back in place. It then streams the N results out in natural order and holds Done until Ack. It replaces manual memory handling and ad-hoc pointer logic with a single self-contained frame engine.

## Interface
- PRE, 32: sample width (signed two's complement, real and imaginary each)
- LOGN, 8: log2 of FFT length; N = 2^LOGN; legal range 1..10
- Clk  in  1  clock, all activity on rising edge
- Reset  in  1  synchronous, active-high
- Start  in  1  begin a frame; sampled only in IDLE
- Ack  in  1  release from DONE; sampled only in DONE
- in_valid  in  1  input sample valid
- in_ready  out  1  sequencer accepts input sample
- in_re, in_im  in  PRE  input sample, signed
- out_valid  out  1  output sample valid
- out_ready  in  1  consumer accepts output sample
- out_re, out_im  out  PRE  output sample, signed
- out_index  out  LOGN  frequency bin of current output
- bf_address  out  10  twiddle index to butterfly (1024-entry twiddle table)
- bf_x_top_re, bf_x_top_im, bf_x_bot_re, bf_x_bot_im  out  PRE  butterfly operands
- bf_y_top_re, bf_y_top_im, bf_y_bot_re, bf_y_bot_im  in  PRE  butterfly results
- Done  out  1  frame complete, high only in DONE
- state  out  4  current state encoding

## Operation
- States and encodings: IDLE=0, DONE=1, PROC=2, LOAD=3, UNLOAD=4. No other values reachable.
- IDLE: on Start=1, go to LOAD; clear the sample counter k, stage counter s and butterfly counter b.
- LOAD: in_ready=1. On a transfer (in_valid & in_ready), write the sample to mem[bitrev_LOGN(k)] and increment k. After the transfer with k=N-1, go to PROC.
- PROC: one butterfly per cycle. half=2^s.
  - i_top = ((b >> s) << (s+1)) | (b & (half-1)); i_bot = i_top + half.
  - bf_x_* = mem[i_top], mem[i_bot], read combinationally.
  - bf_address = (b & (half-1)) << (9-s), zero-extended to 10 bits.
  - At the clock edge, write bf_y_top_* to mem[i_top] and bf_y_bot_* to mem[i_bot].
  - b increments 0..N/2-1. On wrap, b returns to 0 and s increments. After s=LOGN-1, b=N/2-1, go to UNLOAD with k cleared.
- UNLOAD: out_valid=1, out_index=k, out_re/out_im=mem[k]. On a transfer (out_valid & out_ready), increment k. After the transfer with k=N-1, go to DONE.
- DONE: Done=1. On Ack=1, go to IDLE.
- Arithmetic: the sequencer neither scales nor saturates. Butterfly results are stored exactly as PRE-bit values; growth headroom is the caller's responsibility.
- Start outside IDLE is ignored. Ack outside DONE is ignored. In DONE with Start and Ack both high, go to IDLE; Start is not latched.
- Reset mid-operation: state goes to IDLE at the next edge and all counters clear. Memory contents are left unchanged and are not guaranteed.
- When not in PROC, bf_address=0 and bf_x_* values are don't-care.

## Timing
- Reset values: state=0, Done=0, in_ready=0, out_valid=0, out_index=0, bf_address=0, k=s=b=0.
- in_ready, out_valid and Done are decoded from registered state only; there is no combinational path from in_valid or out_ready.
- Start high at edge E moves state to LOAD at E+1. in_ready is first high in the cycle after E.
- LOAD takes N transfer cycles minimum, with no bubbles required.
- PROC lasts exactly LOGN·N/2 cycles (1024 for N=256) with no stalls. The first PROC cycle presents i_top=0, i_bot=1, bf_address=0.
- UNLOAD takes N transfer cycles minimum. out_* hold stable while out_valid & !out_ready.
- Minimum Start-to-Done: 1 + N + LOGN·N/2 + N cycles.
- Ack high at edge A moves state to IDLE, with Done=0, at A+1.

## Test plan
- Impulse: load x[0]=1000, all other samples 0 -> every output is re=1000, im=0; Done rises exactly 1024 cycles after the last load transfer plus N unload transfers (N=256).
- DC: all 256 samples re=100, im=0 -> out_index 0 gives 25600; every other bin is within ±LOGN of 0 (twiddle rounding).
- Address trace: at PROC stage 2, b=5 -> i_top=9, i_bot=13, bf_address=128. Every stage-0 address is 0. At stage 7, b=127 -> i_top=127, i_bot=255, bf_address=508.
- Backpressure: in_valid randomly 50%, out_ready randomly 50% -> out_index sequence is exactly 0..255 with no drops or duplicates, and out_* stay stable while stalled.
- Reset at PROC cycle 300 -> next cycle state=0, Done=0, in_ready=0. A subsequent Start and impulse frame completes correctly.
- Start pulsed during PROC -> no effect. Start and Ack together in DONE -> IDLE; the next cycle stays IDLE with in_ready=0.
